// File: rtl/jtag_dr_stream_bridge_if.sv
// Stream bundle for jtag_dr_stream_bridge.
//   m_data/m_valid/m_ready : upload FIFO head, valid/ready handshake
//   s_result/s_result_valid: result word loaded into the readback register
// master = bridge side, slave = datapath side.
interface jtag_dr_stream_bridge_if #(
    parameter int IN_WIDTH  = 8,
    parameter int OUT_WIDTH = 16
);
    logic [IN_WIDTH-1:0]  m_data;
    logic                 m_valid;
    logic                 m_ready;
    logic [OUT_WIDTH-1:0] s_result;
    logic                 s_result_valid;

    modport master (output m_data, m_valid, input m_ready, s_result, s_result_valid);
    modport slave  (input m_data, m_valid, output m_ready, s_result, s_result_valid);
endinterface

// File: rtl/jtag_dr_stream_bridge.sv
// BSCAN USER4 data-register bridge.
// Upload scans of IN_WIDTH bits (LSB first) become words in a FIFO that is
// drained over a valid/ready stream. Readback scans of READ_WIDTH bits shift
// out the result register, optionally topped with 3 status bits.
// Ports:
//   tck, test_logic_reset     : clock, synchronous active-high reset
//   tdi / tdo                 : serial data in / out (tdo = out_sreg[0])
//   run_test_idle             : informational only
//   ir_is_user                : IR holds USER4; DR events ignored when low
//   capture_dr/shift_dr/update_dr : TAP DR state strobes
//   bus                       : stream interface (master modport)
//   overflow, scan_error      : sticky error flags
module jtag_dr_stream_bridge #(
    parameter int IN_WIDTH   = 8,
    parameter int OUT_WIDTH  = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int STATUS_EN  = 0
) (
    input  logic tck,
    input  logic test_logic_reset,
    input  logic tdi,
    output logic tdo,
    input  logic run_test_idle,
    input  logic ir_is_user,
    input  logic capture_dr,
    input  logic shift_dr,
    input  logic update_dr,
    jtag_dr_stream_bridge_if.master bus,
    output logic overflow,
    output logic scan_error
);
    localparam int READ_WIDTH = OUT_WIDTH + 3 * STATUS_EN;
    localparam int MAX_W      = (IN_WIDTH > READ_WIDTH) ? IN_WIDTH : READ_WIDTH;
    localparam int CW         = $clog2(MAX_W + 1);
    localparam int AW         = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] CNT_IN  = CW'(IN_WIDTH);
    localparam logic [CW-1:0] CNT_RD  = CW'(READ_WIDTH);
    localparam logic [CW-1:0] CNT_SAT = '1;
    localparam logic [AW:0]   FILL_FULL = (AW+1)'(FIFO_DEPTH);

    // An upload and a readback of equal length could not be told apart.
    if (READ_WIDTH == IN_WIDTH) begin : g_width_err
        $error("jtag_dr_stream_bridge: READ_WIDTH must differ from IN_WIDTH");
    end

    logic unused_in;
    assign unused_in = run_test_idle;

    logic [CW-1:0]         bit_cnt;
    logic [IN_WIDTH-1:0]   in_sreg;
    logic [READ_WIDTH-1:0] out_sreg;
    logic [READ_WIDTH-1:0] frame;
    logic [OUT_WIDTH-1:0]  result;
    logic                  result_valid;

    logic [IN_WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [AW:0]           fill;

    // TAP strobes are mutually exclusive in a real TAP; priority only matters
    // for a misbehaving driver.
    logic dr_cap, dr_shift, dr_upd;
    assign dr_cap   = ir_is_user && capture_dr;
    assign dr_shift = ir_is_user && shift_dr && !capture_dr;
    assign dr_upd   = ir_is_user && update_dr && !capture_dr && !shift_dr;

    logic upd_in, upd_rd, upd_bad;
    assign upd_in  = dr_upd && (bit_cnt == CNT_IN);
    assign upd_rd  = dr_upd && (bit_cnt == CNT_RD);
    assign upd_bad = dr_upd && !upd_in && !upd_rd;

    logic pop, full, push, ovf_set, flag_clr;
    assign pop      = bus.m_valid && bus.m_ready;
    assign full     = (fill == FILL_FULL);
    assign push     = upd_in && (!full || pop);
    assign ovf_set  = upd_in && full && !pop;
    assign flag_clr = upd_rd && (STATUS_EN != 0);

    if (STATUS_EN != 0) begin : g_status
        assign frame = {result_valid, overflow, scan_error, result};
    end else begin : g_plain
        assign frame = result;
    end

    assign tdo         = out_sreg[0];
    assign bus.m_data  = mem[rd_ptr];
    assign bus.m_valid = (fill != '0);

    // Scan shift registers and bit counter
    always_ff @(posedge tck) begin
        if (test_logic_reset) begin
            bit_cnt  <= '0;
            in_sreg  <= '0;
            out_sreg <= '0;
        end else if (!ir_is_user) begin
            bit_cnt <= '0;
        end else if (dr_cap) begin
            bit_cnt  <= '0;
            out_sreg <= frame;
        end else if (dr_shift) begin
            in_sreg  <= {tdi, in_sreg[IN_WIDTH-1:1]};
            out_sreg <= {1'b0, out_sreg[READ_WIDTH-1:1]};
            if (bit_cnt != CNT_SAT)
                bit_cnt <= bit_cnt + 1'b1;
        end
    end

    // Result register
    always_ff @(posedge tck) begin
        if (test_logic_reset) begin
            result       <= '0;
            result_valid <= 1'b0;
        end else if (bus.s_result_valid) begin
            result       <= bus.s_result;
            result_valid <= 1'b1;
        end
    end

    // Sticky flags: a set beats a same-cycle clear
    always_ff @(posedge tck) begin
        if (test_logic_reset) begin
            overflow   <= 1'b0;
            scan_error <= 1'b0;
        end else begin
            if (ovf_set)       overflow <= 1'b1;
            else if (flag_clr) overflow <= 1'b0;
            if (upd_bad)       scan_error <= 1'b1;
            else if (flag_clr) scan_error <= 1'b0;
        end
    end

    // Upload FIFO
    always_ff @(posedge tck) begin
        if (test_logic_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_sreg;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            fill <= fill + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
endmodule

// File: tb/tb_jtag_dr_stream_bridge.sv
module tb_jtag_dr_stream_bridge;
    logic tck = 1'b0;
    logic test_logic_reset, tdi, run_test_idle;
    logic capture_dr, shift_dr, update_dr;
    logic ir0, ir1;
    logic tdo0, tdo1, overflow0, overflow1, scan_error0, scan_error1;

    int total = 0;
    int bad   = 0;
    logic [7:0]  exp_q[$];
    logic [31:0] rd;

    always #5 tck = ~tck;

    jtag_dr_stream_bridge_if #(.IN_WIDTH(8), .OUT_WIDTH(16)) if0 ();
    jtag_dr_stream_bridge_if #(.IN_WIDTH(8), .OUT_WIDTH(16)) if1 ();

    jtag_dr_stream_bridge #(.IN_WIDTH(8), .OUT_WIDTH(16), .FIFO_DEPTH(16), .STATUS_EN(0)) u0 (
        .tck(tck), .test_logic_reset(test_logic_reset), .tdi(tdi), .tdo(tdo0),
        .run_test_idle(run_test_idle), .ir_is_user(ir0), .capture_dr(capture_dr),
        .shift_dr(shift_dr), .update_dr(update_dr), .bus(if0.master),
        .overflow(overflow0), .scan_error(scan_error0)
    );

    jtag_dr_stream_bridge #(.IN_WIDTH(8), .OUT_WIDTH(16), .FIFO_DEPTH(16), .STATUS_EN(1)) u1 (
        .tck(tck), .test_logic_reset(test_logic_reset), .tdi(tdi), .tdo(tdo1),
        .run_test_idle(run_test_idle), .ir_is_user(ir1), .capture_dr(capture_dr),
        .shift_dr(shift_dr), .update_dr(update_dr), .bus(if1.master),
        .overflow(overflow1), .scan_error(scan_error1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard check happens just before the edge that performs the pop.
    task automatic tick();
        if (if0.m_valid === 1'b1 && if0.m_ready === 1'b1) begin
            if (exp_q.size() == 0)
                chk("extra_word", 32'(exp_q.size()), 32'd1);
            else
                chk("m_data", 32'(if0.m_data), 32'(exp_q.pop_front()));
        end
        @(negedge tck);
    endtask

    task automatic do_reset();
        if0.m_ready = 1'b0;
        test_logic_reset = 1'b1;
        tick();
        test_logic_reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic scan(input logic [31:0] data, input int n, input bit which,
                        input bit chk_lat, input bit rdy_upd, output logic [31:0] bits);
        bits = '0;
        capture_dr = 1'b1;
        tick();
        capture_dr = 1'b0;
        for (int i = 0; i < n; i++) begin
            shift_dr = 1'b1;
            tdi      = data[i];
            bits[i]  = which ? tdo1 : tdo0;
            tick();
        end
        shift_dr = 1'b0;
        tdi      = 1'b0;
        if (chk_lat) chk("lat_pre", 32'(if0.m_valid), 32'd0);
        if (rdy_upd) if0.m_ready = 1'b1;
        update_dr = 1'b1;
        tick();
        update_dr = 1'b0;
        if (chk_lat) chk("lat_post", 32'(if0.m_valid), 32'd1);
        tick();
    endtask

    initial begin
        test_logic_reset = 1'b1; tdi = 1'b0; run_test_idle = 1'b0;
        capture_dr = 1'b0; shift_dr = 1'b0; update_dr = 1'b0;
        ir0 = 1'b1; ir1 = 1'b0;
        if0.m_ready = 1'b0; if0.s_result = '0; if0.s_result_valid = 1'b0;
        if1.m_ready = 1'b0; if1.s_result = '0; if1.s_result_valid = 1'b0;
        @(negedge tck);
        tick();
        test_logic_reset = 1'b0;

        // Reset state
        chk("rst_tdo",       32'(tdo0),        32'd0);
        chk("rst_m_valid",   32'(if0.m_valid), 32'd0);
        chk("rst_m_data",    32'(if0.m_data),  32'd0);
        chk("rst_overflow",  32'(overflow0),   32'd0);
        chk("rst_scan_err",  32'(scan_error0), 32'd0);
        chk("rst_tdo_st",    32'(tdo1),        32'd0);

        // "L68\n" with consumer ready
        if0.m_ready = 1'b1;
        begin
            logic [7:0] msg [4];
            msg[0] = 8'h4C; msg[1] = 8'h36; msg[2] = 8'h38; msg[3] = 8'h0A;
            for (int i = 0; i < 4; i++) begin
                exp_q.push_back(msg[i]);
                scan(32'(msg[i]), 8, 1'b0, 1'b1, 1'b0, rd);
            end
        end
        tick(); tick();
        chk("l68_drained",   32'(exp_q.size()), 32'd0);
        chk("l68_overflow",  32'(overflow0),    32'd0);
        chk("l68_scan_err",  32'(scan_error0),  32'd0);

        // Overflow: 17 uploads into a 16-deep FIFO, consumer stalled
        if0.m_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            if (i < 16) exp_q.push_back(8'(i));
            scan(32'(i), 8, 1'b0, 1'b0, 1'b0, rd);
        end
        chk("ovf_flag",      32'(overflow0),   32'd1);
        chk("ovf_head_hold", 32'(if0.m_data),  32'h00);
        chk("ovf_valid",     32'(if0.m_valid), 32'd1);
        chk("ovf_scan_err",  32'(scan_error0), 32'd0);
        if0.m_ready = 1'b1;
        repeat (20) tick();
        chk("ovf_drained",   32'(exp_q.size()), 32'd0);
        chk("ovf_empty",     32'(if0.m_valid),  32'd0);

        // Result readback
        do_reset();
        chk("rst2_overflow", 32'(overflow0), 32'd0);
        if0.s_result = 16'h1234; if0.s_result_valid = 1'b1;
        tick();
        if0.s_result_valid = 1'b0;
        scan(32'd0, 16, 1'b0, 1'b0, 1'b0, rd);
        chk("rb_value",      32'(rd[15:0]),    32'h1234);
        chk("rb_no_push",    32'(if0.m_valid), 32'd0);
        chk("rb_scan_err",   32'(scan_error0), 32'd0);

        // Bad scan lengths
        scan(32'h1F, 5, 1'b0, 1'b0, 1'b0, rd);
        chk("len5_no_push",  32'(if0.m_valid), 32'd0);
        chk("len5_scan_err", 32'(scan_error0), 32'd1);
        do_reset();
        scan(32'd0, 0, 1'b0, 1'b0, 1'b0, rd);
        chk("len0_no_push",  32'(if0.m_valid), 32'd0);
        chk("len0_scan_err", 32'(scan_error0), 32'd1);

        // Status readback on the STATUS_EN instance
        ir0 = 1'b0; ir1 = 1'b1;
        if1.s_result = 16'h1234; if1.s_result_valid = 1'b1;
        tick();
        if1.s_result_valid = 1'b0;
        scan(32'h1F, 5, 1'b1, 1'b0, 1'b0, rd);
        chk("st_len5_err",   32'(scan_error1), 32'd1);
        scan(32'd0, 19, 1'b1, 1'b0, 1'b0, rd);
        chk("st_rb_value",   32'(rd[18:0]),    32'h51234);
        chk("st_err_clr",    32'(scan_error1), 32'd0);
        chk("st_ovf",        32'(overflow1),   32'd0);
        chk("st_no_push",    32'(if1.m_valid), 32'd0);

        // IR not USER4: full scan ignored, flags untouched
        ir1 = 1'b0;
        scan(32'hFF, 8, 1'b0, 1'b0, 1'b0, rd);
        chk("noir_no_push",  32'(if0.m_valid), 32'd0);
        chk("noir_scan_err", 32'(scan_error0), 32'd1);
        chk("noir_overflow", 32'(overflow0),   32'd0);

        // Reset in the middle of a shift discards the partial word
        ir0 = 1'b1;
        capture_dr = 1'b1; tick(); capture_dr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            shift_dr = 1'b1; tdi = 1'b1; tick();
        end
        test_logic_reset = 1'b1; tick();
        test_logic_reset = 1'b0; shift_dr = 1'b0; tdi = 1'b0; tick();
        exp_q.delete();
        if0.m_ready = 1'b1;
        exp_q.push_back(8'h5A);
        scan(32'h5A, 8, 1'b0, 1'b0, 1'b0, rd);
        repeat (4) tick();
        chk("mid_one_word",  32'(exp_q.size()), 32'd0);
        chk("mid_empty",     32'(if0.m_valid),  32'd0);
        chk("mid_scan_err",  32'(scan_error0),  32'd0);

        // Full FIFO: push coincides with a pop
        do_reset();
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(8'(8'h80 + i));
            scan(32'(8'h80 + i), 8, 1'b0, 1'b0, 1'b0, rd);
        end
        chk("full_overflow", 32'(overflow0), 32'd0);
        exp_q.push_back(8'hEE);
        scan(32'hEE, 8, 1'b0, 1'b0, 1'b1, rd);
        chk("coinc_overflow", 32'(overflow0), 32'd0);
        repeat (24) tick();
        chk("coinc_drained", 32'(exp_q.size()), 32'd0);
        chk("coinc_empty",   32'(if0.m_valid),  32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
